ddr_wr_packer: RTL and testbench
================================

DDR_WR_PACKER -- requirements
Module: ddr_wr_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 64, input beat width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 512, packed word width; OUT_WIDTH/IN_WIDTH (RATIO, default 8) is an integer.
REQ-003 SHALL have parameter PAD_VALUE, default 64'h0, fill value for unused lanes of a flushed word.
REQ-004 SHALL have parameter COMPLETE_HOLD, default 4, o_complete high-time in cycles, at least 3.
REQ-005 SHALL use one clock and an asynchronous active-low reset: `ddr_ui_clk in 1`, the single clock, and `ddr_log_rst_n in 1`, the asynchronous active-low reset.
REQ-006 `i_data_en in 1`, input beat valid; `i_data in IN_WIDTH`, beat payload; `i_frame_end in 1`, last beat of frame, qualified by i_data_en.
REQ-007 `o_ready out 1`, beat accepted only when high.
REQ-008 `o_fifo_wr_en out 1`, `o_fifo_wr_data out OUT_WIDTH`, `i_fifo_full in 1`, `i_fifo_prog_full in 1`, write port of the 512-bit FIFO read by the DDR write controller.
REQ-009 `o_complete out 1`, frame-flushed strobe to the DDR controller's complete input; `o_overflow out 1`, sticky error flag.
REQ-010 `o_word_cnt out 32`, words written; `o_drop_cnt out 16`, beats and words dropped.

Function
REQ-011 SHALL define the beat-accept condition as i_data_en AND o_ready.
REQ-012 SHALL drive o_ready = (state==PACK) AND NOT i_fifo_prog_full.
REQ-013 SHALL place the k-th accepted beat of a word (k=0..RATIO-1) in bits [k*IN_WIDTH +: IN_WIDTH], with lane 0 = LSBs.
REQ-014 SHALL, on accepting beat RATIO-1, pulse o_fifo_wr_en for exactly one cycle in the next cycle with the full word registered, and reset the lane counter to 0.
REQ-015 SHALL, on accepting a beat with i_frame_end=1 at lane k<RATIO-1, fill lanes k+1..RATIO-1 with PAD_VALUE and write the word next cycle as in REQ-014.
REQ-016 SHALL use states PACK, then DONE: PACK transitions to DONE on an accepted frame-end beat; DONE lasts COMPLETE_HOLD cycles and then returns to PACK.
REQ-017 SHALL hold o_complete high throughout DONE, starting the cycle after the final o_fifo_wr_en, and hold o_ready low during DONE.
REQ-018 SHALL ignore i_frame_end when i_data_en=0.
REQ-019 SHALL, when i_data_en=1 and o_ready=0, drop the beat, set o_overflow and increment o_drop_cnt.
REQ-020 SHALL, if a write is due while i_fifo_full=1, suppress o_fifo_wr_en, discard the word, set o_overflow and increment o_drop_cnt.
REQ-021 SHALL clear o_overflow only by reset.
REQ-022 SHALL saturate o_drop_cnt at 16'hFFFF and let o_word_cnt wrap modulo 2^32.
REQ-023 SHALL increment o_word_cnt once per asserted o_fifo_wr_en.

Reset
REQ-024 SHALL, on ddr_log_rst_n=0, asynchronously clear all outputs, lane counter, partial word and counters to 0, and set state to PACK.
REQ-025 SHALL discard a partial word when reset asserts mid-frame, with no write and no o_complete.
REQ-026 SHALL drive o_ready=0 while reset is asserted.

Configuration
REQ-027 SHALL, with macro DDR_WR_PACKER_STAT_EN defined, implement o_word_cnt and o_drop_cnt per REQ-019..023.
REQ-028 SHALL, without DDR_WR_PACKER_STAT_EN, tie o_word_cnt and o_drop_cnt to 0 and synthesize no counter logic; o_overflow is unaffected.

Structure
REQ-029 SHALL place the state encoding (PACK, DONE), RATIO and the lane-index width in shared package ddr_pack_pkg.
REQ-030 SHALL implement the COMPLETE_HOLD counter and o_complete generation in sub-module ddr_complete_stretch; the packing datapath stays in ddr_wr_packer.

Verification
REQ-031 SHALL cover: 8 beats 64'h1..64'h8, no frame_end -> one write 1 cycle after beat 8, data {8,7,...,1}, o_complete stays 0.
REQ-032 SHALL cover: 16 beats with frame_end on beat 16 -> two writes, o_complete high 4 cycles starting the cycle after the 2nd write, o_word_cnt=2.
REQ-033 SHALL cover: 3 beats A,B,C with frame_end on C -> one write, lanes 0-2 = A,B,C, lanes 3-7 = 0.
REQ-034 SHALL cover: i_fifo_prog_full=1 with i_data_en=1 for 1 cycle -> o_ready=0, no lane advance, o_overflow=1, o_drop_cnt=1.
REQ-035 SHALL cover: reset pulse after 5 accepted beats, then 8 beats -> exactly one write, containing only the 8 post-reset beats.
REQ-036 SHALL cover: build without DDR_WR_PACKER_STAT_EN and repeat REQ-032 -> writes identical, o_word_cnt=0, o_drop_cnt=0.

Source files
------------

// File: rtl/ddr_pack_pkg.sv
// rtl/ddr_pack_pkg.sv - shared state encoding and lane geometry for the DDR write packer
//
// Purpose: common types and constants for ddr_wr_packer and ddr_complete_stretch.
// Ports:   none (package).
package ddr_pack_pkg;

   typedef enum logic [0:0] {
      PACK = 1'b0,
      DONE = 1'b1
   } pack_state_e;

   localparam int DEF_IN_WIDTH  = 64;
   localparam int DEF_OUT_WIDTH = 512;
   localparam int RATIO         = DEF_OUT_WIDTH / DEF_IN_WIDTH;

   // Lane index width for a given beats-per-word ratio; never narrower than 1 bit.
   function automatic int lane_width(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   localparam int LANE_W = lane_width(RATIO);

endpackage

// File: rtl/ddr_wr_packer_if.sv
// rtl/ddr_wr_packer_if.sv - beat input and packed-word FIFO write bundle
//
// Purpose: groups the beat stream (i_data_en/i_data/i_frame_end/o_ready) and the
//          wide FIFO write port (o_fifo_wr_en/o_fifo_wr_data/i_fifo_full/i_fifo_prog_full).
// Modports: master - beat source and FIFO side; slave - the packer.
interface ddr_wr_packer_if #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 512
);
   logic                 i_data_en;
   logic [IN_WIDTH-1:0]  i_data;
   logic                 i_frame_end;
   logic                 o_ready;
   logic                 o_fifo_wr_en;
   logic [OUT_WIDTH-1:0] o_fifo_wr_data;
   logic                 i_fifo_full;
   logic                 i_fifo_prog_full;

   modport master (
      output i_data_en, i_data, i_frame_end, i_fifo_full, i_fifo_prog_full,
      input  o_ready, o_fifo_wr_en, o_fifo_wr_data
   );

   modport slave (
      input  i_data_en, i_data, i_frame_end, i_fifo_full, i_fifo_prog_full,
      output o_ready, o_fifo_wr_en, o_fifo_wr_data
   );
endinterface

// File: rtl/ddr_complete_stretch.sv
// rtl/ddr_complete_stretch.sv - frame-complete strobe stretcher
//
// Purpose: after a frame-end beat is accepted (i_start), skips the cycle in which
//          the final word is written, then holds o_complete high for COMPLETE_HOLD
//          cycles. o_last marks the final cycle of the hold window.
// Ports:   clk, rst_n (async active-low), i_start, o_complete, o_last.
module ddr_complete_stretch
   import ddr_pack_pkg::*;
#(
   parameter int COMPLETE_HOLD = 4   // must be at least 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_start,
   output logic o_complete,
   output logic o_last
);
   localparam int CW = $clog2(COMPLETE_HOLD + 1);

   logic          arm_q, arm_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          complete_q, complete_d;

   // arm_q covers the cycle in which the last word is on the FIFO port; the
   // counter loads there so o_complete rises exactly one cycle after that write.
   always_comb begin
      arm_d = i_start;
      cnt_d = cnt_q;
      if (arm_q) begin
         cnt_d = CW'(COMPLETE_HOLD);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      complete_d = arm_q || (cnt_q > CW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_q      <= 1'b0;
         cnt_q      <= '0;
         complete_q <= 1'b0;
      end else begin
         arm_q      <= arm_d;
         cnt_q      <= cnt_d;
         complete_q <= complete_d;
      end
   end

   assign o_complete = complete_q;
   assign o_last     = (cnt_q == CW'(1));

endmodule

// File: rtl/ddr_wr_packer.sv
// rtl/ddr_wr_packer.sv - packs narrow input beats into wide DDR FIFO words
//
// Purpose: collects OUT_WIDTH/IN_WIDTH beats (lane 0 = LSBs) into one word and
//          writes it to the DDR write FIFO; a frame-end beat pads the remaining
//          lanes with PAD_VALUE, flushes, and raises o_complete for COMPLETE_HOLD
//          cycles. Dropped beats/words set sticky o_overflow.
// Ports:   ddr_ui_clk, ddr_log_rst_n (async active-low), bus (ddr_wr_packer_if.slave),
//          o_complete, o_overflow, o_word_cnt[31:0], o_drop_cnt[15:0].
// Config:  DDR_WR_PACKER_STAT_EN - when defined, o_word_cnt/o_drop_cnt count;
//          otherwise both are tied to 0.
module ddr_wr_packer
   import ddr_pack_pkg::*;
#(
   parameter int                  IN_WIDTH      = DEF_IN_WIDTH,
   parameter int                  OUT_WIDTH     = DEF_OUT_WIDTH,
   parameter logic [IN_WIDTH-1:0] PAD_VALUE     = '0,
   parameter int                  COMPLETE_HOLD = 4
) (
   input  logic                  ddr_ui_clk,
   input  logic                  ddr_log_rst_n,
   ddr_wr_packer_if.slave        bus,
   output logic                  o_complete,
   output logic                  o_overflow,
   output logic [31:0]           o_word_cnt,
   output logic [15:0]           o_drop_cnt
);
   localparam int            RATIO_P   = OUT_WIDTH / IN_WIDTH;
   localparam int            LW        = lane_width(RATIO_P);
   localparam logic [LW-1:0] LAST_LANE = LW'(RATIO_P - 1);

   pack_state_e          state_q, state_d;
   logic [LW-1:0]        lane_q, lane_d;
   logic [OUT_WIDTH-1:0] word_q, word_d;
   logic                 wr_en_q, wr_en_d;
   logic [OUT_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                 overflow_q, overflow_d;

   logic                 ready;
   logic                 accept;
   logic                 wr_due;
   logic                 frame_done;
   logic                 drop_beat;
   logic                 drop_word;
   logic                 stretch_last;
   logic [OUT_WIDTH-1:0] merged;

   // Reset gates o_ready directly: state_q already reads PACK while in reset.
   assign ready      = ddr_log_rst_n && (state_q == PACK) && !bus.i_fifo_prog_full;
   assign accept     = bus.i_data_en && ready;
   assign drop_beat  = bus.i_data_en && !ready;
   assign wr_due     = accept && ((lane_q == LAST_LANE) || bus.i_frame_end);
   assign frame_done = accept && bus.i_frame_end;
   // FIFO fullness is judged in the cycle the word becomes due.
   assign drop_word  = wr_due && bus.i_fifo_full;

   // Current beat goes into lane_q; lanes above it are pre-filled with PAD_VALUE
   // so a frame-end flush needs no extra step (later beats overwrite them).
   always_comb begin
      merged = word_q;
      for (int j = 0; j < RATIO_P; j++) begin
         if (j == int'(lane_q)) begin
            merged[j*IN_WIDTH +: IN_WIDTH] = bus.i_data;
         end else if (j > int'(lane_q)) begin
            merged[j*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      word_d     = word_q;
      wr_en_d    = 1'b0;
      wr_data_d  = wr_data_q;
      overflow_d = overflow_q || drop_beat || drop_word;
      if (accept) begin
         word_d = merged;
         lane_d = wr_due ? '0 : lane_q + 1'b1;
         if (wr_due && !bus.i_fifo_full) begin
            wr_en_d   = 1'b1;
            wr_data_d = merged;
         end
      end
      // DONE spans the final-write cycle plus the o_complete window.
      case (state_q)
         PACK:    if (frame_done)   state_d = DONE;
         DONE:    if (stretch_last) state_d = PACK;
         default: state_d = PACK;
      endcase
   end

   always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
      if (!ddr_log_rst_n) begin
         state_q    <= PACK;
         lane_q     <= '0;
         word_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         wr_en_q    <= wr_en_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
      end
   end

   ddr_complete_stretch #(
      .COMPLETE_HOLD (COMPLETE_HOLD)
   ) u_complete_stretch (
      .clk        (ddr_ui_clk),
      .rst_n      (ddr_log_rst_n),
      .i_start    (frame_done),
      .o_complete (o_complete),
      .o_last     (stretch_last)
   );

   assign bus.o_ready        = ready;
   assign bus.o_fifo_wr_en   = wr_en_q;
   assign bus.o_fifo_wr_data = wr_data_q;
   assign o_overflow         = overflow_q;

`ifdef DDR_WR_PACKER_STAT_EN
   logic [31:0] word_cnt_q, word_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Counting on wr_en_d keeps o_word_cnt in step with o_fifo_wr_en.
   always_comb begin
      word_cnt_d = word_cnt_q + {31'd0, wr_en_d};
      drop_cnt_d = drop_cnt_q;
      if ((drop_beat || drop_word) && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge ddr_ui_clk or negedge ddr_log_rst_n) begin
      if (!ddr_log_rst_n) begin
         word_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_word_cnt = word_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`else
   assign o_word_cnt = '0;
   assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_wr_packer.sv
// tb/tb_ddr_wr_packer.sv - directed self-checking bench for ddr_wr_packer
module tb_ddr_wr_packer;
   import ddr_pack_pkg::*;

`ifdef DDR_WR_PACKER_STAT_EN
   localparam bit STAT = 1'b1;
`else
   localparam bit STAT = 1'b0;
`endif

   logic        ddr_ui_clk;
   logic        ddr_log_rst_n;
   logic        o_complete;
   logic        o_overflow;
   logic [31:0] o_word_cnt;
   logic [15:0] o_drop_cnt;

   int errors = 0;
   int checks = 0;

   ddr_wr_packer_if #(.IN_WIDTH(64), .OUT_WIDTH(512)) bus ();

   ddr_wr_packer dut (
      .ddr_ui_clk    (ddr_ui_clk),
      .ddr_log_rst_n (ddr_log_rst_n),
      .bus           (bus),
      .o_complete    (o_complete),
      .o_overflow    (o_overflow),
      .o_word_cnt    (o_word_cnt),
      .o_drop_cnt    (o_drop_cnt)
   );

   initial ddr_ui_clk = 1'b0;
   always #5 ddr_ui_clk = ~ddr_ui_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ddr_ui_clk);
      #1;
   endtask

   task automatic idle();
      bus.i_data_en   = 1'b0;
      bus.i_frame_end = 1'b0;
      bus.i_data      = '0;
   endtask

   task automatic beat(input logic [63:0] d, input logic fe);
      bus.i_data_en   = 1'b1;
      bus.i_data      = d;
      bus.i_frame_end = fe;
      tick();
   endtask

   task automatic do_reset();
      idle();
      ddr_log_rst_n = 1'b0;
      tick();
      ddr_log_rst_n = 1'b1;
      #1;
   endtask

   logic [511:0] exp_w;
   logic [511:0] exp_w2;
   logic         seen;

   initial begin
      idle();
      bus.i_fifo_full      = 1'b0;
      bus.i_fifo_prog_full = 1'b0;
      ddr_log_rst_n        = 1'b0;
      #12;
      check("rst_ready",    bus.o_ready, 1'b0);
      check("rst_wr_en",    bus.o_fifo_wr_en, 1'b0);
      check("rst_wr_data",  bus.o_fifo_wr_data, '0);
      check("rst_complete", o_complete, 1'b0);
      check("rst_overflow", o_overflow, 1'b0);
      check("rst_word_cnt", o_word_cnt, 32'd0);
      check("rst_drop_cnt", o_drop_cnt, 16'd0);
      ddr_log_rst_n = 1'b1;
      #1;
      check("ready_after_rst", bus.o_ready, 1'b1);

      // 8 beats 1..8, no frame end; frame_end without data_en mid-word is ignored
      exp_w = '0;
      seen  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         exp_w[k*64 +: 64] = 64'(k + 1);
         beat(64'(k + 1), 1'b0);
         if (k < 7) seen = seen | bus.o_fifo_wr_en;
         if (k == 3) begin
            bus.i_data_en   = 1'b0;
            bus.i_frame_end = 1'b1;
            tick();
            check("fe_no_en_ready", bus.o_ready, 1'b1);
            seen = seen | bus.o_fifo_wr_en;
         end
      end
      check("a_early_write", seen, 1'b0);
      check("a_wr_en",   bus.o_fifo_wr_en, 1'b1);
      check("a_wr_data", bus.o_fifo_wr_data, exp_w);
      idle();
      tick();
      check("a_wr_pulse_end", bus.o_fifo_wr_en, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         seen = seen | o_complete;
         tick();
      end
      check("a_no_complete", seen, 1'b0);
      check("a_word_cnt", o_word_cnt, STAT ? 32'd1 : 32'd0);

      // 16 beats, frame end on the 16th: two writes, 4-cycle complete after the 2nd
      do_reset();
      exp_w  = '0;
      exp_w2 = '0;
      for (int k = 0; k < 16; k++) begin
         if (k < 8) exp_w[k*64 +: 64] = 64'h0B00 + 64'(k);
         else       exp_w2[(k-8)*64 +: 64] = 64'h0B00 + 64'(k);
         beat(64'h0B00 + 64'(k), k == 15);
         if (k == 7) begin
            check("b_wr1_en",   bus.o_fifo_wr_en, 1'b1);
            check("b_wr1_data", bus.o_fifo_wr_data, exp_w);
         end
      end
      check("b_wr2_en",   bus.o_fifo_wr_en, 1'b1);
      check("b_wr2_data", bus.o_fifo_wr_data, exp_w2);
      check("b_done_ready", bus.o_ready, 1'b0);
      check("b_complete_early", o_complete, 1'b0);
      idle();
      for (int c = 0; c < 4; c++) begin
         tick();
         check("b_complete_hi", o_complete, 1'b1);
         check("b_ready_lo",    bus.o_ready, 1'b0);
      end
      tick();
      check("b_complete_end", o_complete, 1'b0);
      check("b_ready_back",   bus.o_ready, 1'b1);
      check("b_word_cnt", o_word_cnt, STAT ? 32'd2 : 32'd0);
      check("b_drop_cnt", o_drop_cnt, 16'd0);
      check("b_overflow", o_overflow, 1'b0);

      // 3 beats, frame end on the 3rd: lanes 3..7 padded with 0
      do_reset();
      exp_w = '0;
      exp_w[0*64 +: 64] = 64'hAAAA_0000_0000_000A;
      exp_w[1*64 +: 64] = 64'hBBBB_0000_0000_000B;
      exp_w[2*64 +: 64] = 64'hCCCC_0000_0000_000C;
      beat(64'hAAAA_0000_0000_000A, 1'b0);
      beat(64'hBBBB_0000_0000_000B, 1'b0);
      beat(64'hCCCC_0000_0000_000C, 1'b1);
      check("c_wr_en",   bus.o_fifo_wr_en, 1'b1);
      check("c_wr_data", bus.o_fifo_wr_data, exp_w);
      idle();
      for (int c = 0; c < 5; c++) tick();
      check("c_ready_back", bus.o_ready, 1'b1);

      // prog_full drop: no lane advance, overflow set; then a full-FIFO word drop
      do_reset();
      exp_w = '0;
      for (int k = 0; k < 2; k++) begin
         exp_w[k*64 +: 64] = 64'h0D00 + 64'(k);
         beat(64'h0D00 + 64'(k), 1'b0);
      end
      bus.i_data_en        = 1'b1;
      bus.i_data           = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.i_frame_end      = 1'b0;
      bus.i_fifo_prog_full = 1'b1;
      #1;
      check("d_ready_pf", bus.o_ready, 1'b0);
      tick();
      bus.i_fifo_prog_full = 1'b0;
      check("d_overflow", o_overflow, 1'b1);
      check("d_drop_cnt", o_drop_cnt, STAT ? 16'd1 : 16'd0);
      for (int k = 2; k < 8; k++) begin
         exp_w[k*64 +: 64] = 64'h0D00 + 64'(k);
         beat(64'h0D00 + 64'(k), 1'b0);
      end
      check("d_wr_en",   bus.o_fifo_wr_en, 1'b1);
      check("d_wr_data", bus.o_fifo_wr_data, exp_w);
      bus.i_fifo_full = 1'b1;
      for (int k = 0; k < 8; k++) beat(64'h0F00 + 64'(k), 1'b0);
      bus.i_fifo_full = 1'b0;
      check("d_full_no_wr", bus.o_fifo_wr_en, 1'b0);
      check("d_full_drop_cnt", o_drop_cnt, STAT ? 16'd2 : 16'd0);
      check("d_full_word_cnt", o_word_cnt, STAT ? 32'd1 : 32'd0);
      idle();
      tick();
      check("d_overflow_sticky", o_overflow, 1'b1);

      // reset after 5 accepted beats discards the partial word
      do_reset();
      check("e_overflow_cleared", o_overflow, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         beat(64'h0500 + 64'(k), 1'b0);
         seen = seen | bus.o_fifo_wr_en | o_complete;
      end
      idle();
      ddr_log_rst_n = 1'b0;
      #1;
      check("e_ready_in_rst", bus.o_ready, 1'b0);
      tick();
      ddr_log_rst_n = 1'b1;
      #1;
      exp_w = '0;
      for (int k = 0; k < 8; k++) begin
         exp_w[k*64 +: 64] = 64'h0E00 + 64'(k);
         beat(64'h0E00 + 64'(k), 1'b0);
         if (k < 7) seen = seen | bus.o_fifo_wr_en | o_complete;
      end
      check("e_no_stray_write", seen, 1'b0);
      check("e_wr_en",   bus.o_fifo_wr_en, 1'b1);
      check("e_wr_data", bus.o_fifo_wr_data, exp_w);
      idle();
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         seen = seen | bus.o_fifo_wr_en | o_complete;
      end
      check("e_single_write", seen, 1'b0);
      check("e_word_cnt", o_word_cnt, STAT ? 32'd1 : 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
